// File: rtl/l2_cache_control.sv
// L2 cache control: qualifies tag matches, holds valid/dirty/LRU arrays and
// sequences hit, writeback and allocate transactions against physical memory.
module l2_cache_control #(
  parameter int unsigned S_INDEX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  output logic        mem_resp,
  input  logic        tag_match1,
  input  logic        tag_match2,
  output logic        hit1,
  output logic        hit2,
  output logic        load_way1,
  output logic        load_way2,
  output logic        data_sel,
  output logic        pmem_addr_sel,
  output logic        victim_way,
  output logic        pmem_read,
  output logic        pmem_write,
  input  logic        pmem_resp
);

  localparam int unsigned NSETS = 1 << S_INDEX;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t             r_state;
  logic [NSETS-1:0]   r_valid1, r_valid2, r_dirty1, r_dirty2, r_lru;

  logic [S_INDEX-1:0] w_idx;
  logic               w_req, w_hit, w_victim_dirty;
  logic               w_unused_addr;

  assign w_idx         = mem_address[4+S_INDEX:5];
  assign w_unused_addr = ^{mem_address[31:5+S_INDEX], mem_address[4:0]};
  assign w_req         = mem_read | mem_write;

  // Way1 wins when both ways report a valid match.
  assign hit1       = tag_match1 & r_valid1[w_idx];
  assign hit2       = tag_match2 & r_valid2[w_idx] & ~hit1;
  assign w_hit      = hit1 | hit2;
  assign victim_way = r_lru[w_idx];
  assign w_victim_dirty = victim_way ? (r_valid2[w_idx] & r_dirty2[w_idx])
                                     : (r_valid1[w_idx] & r_dirty1[w_idx]);

  always_comb begin
    mem_resp      = 1'b0;
    load_way1     = 1'b0;
    load_way2     = 1'b0;
    data_sel      = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    unique case (r_state)
      COMPARE: begin
        if (w_req && w_hit) begin
          mem_resp = 1'b1;
          if (mem_write) begin
            load_way1 = hit1;
            load_way2 = hit2;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_sel  = 1'b1;
          load_way1 = ~victim_way;
          load_way2 = victim_way;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_valid1 <= '0;
      r_valid2 <= '0;
      r_dirty1 <= '0;
      r_dirty2 <= '0;
      r_lru    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) r_state <= COMPARE;
        end
        COMPARE: begin
          if (!w_req) begin
            r_state <= IDLE;
          end else if (w_hit) begin
            r_lru[w_idx] <= hit1;
            if (mem_write) begin
              if (hit1) r_dirty1[w_idx] <= 1'b1;
              else      r_dirty2[w_idx] <= 1'b1;
            end
            r_state <= IDLE;
          end else if (w_victim_dirty) begin
            r_state <= WRITEBACK;
          end else begin
            r_state <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            if (victim_way) r_dirty2[w_idx] <= 1'b0;
            else            r_dirty1[w_idx] <= 1'b0;
            r_state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            if (victim_way) begin
              r_valid2[w_idx] <= 1'b1;
              r_dirty2[w_idx] <= 1'b0;
            end else begin
              r_valid1[w_idx] <= 1'b1;
              r_dirty1[w_idx] <= 1'b0;
            end
            r_state <= COMPARE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_control.sv
// Self-checking bench for l2_cache_control: directed plan plus random traffic
// against a transaction-level model of the cache's valid/dirty/LRU/tag state.
module tb_l2_cache_control;

  localparam int unsigned S_INDEX = 3;
  localparam int unsigned NSETS   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_address;
  logic        mem_resp;
  logic        tag_match1, tag_match2;
  logic        hit1, hit2;
  logic        load_way1, load_way2;
  logic        data_sel, pmem_addr_sel, victim_way;
  logic        pmem_read, pmem_write, pmem_resp;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Datapath tag arrays (loaded by the DUT's load enables) and the model state.
  logic [23:0] dp_tag [0:1][0:NSETS-1];
  logic [23:0] mtag   [0:1][0:NSETS-1];
  bit          mval   [0:1][0:NSETS-1];
  bit          mdir   [0:1][0:NSETS-1];
  bit          mlru   [0:NSETS-1];

  logic [2:0]  w_set;
  logic [23:0] w_tag;
  assign w_set = mem_address[7:5];
  assign w_tag = mem_address[31:8];
  assign tag_match1 = (dp_tag[0][w_set] == w_tag);
  assign tag_match2 = (dp_tag[1][w_set] == w_tag);

  always #5 clk = ~clk;

  l2_cache_control #(.S_INDEX(S_INDEX)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_resp(mem_resp),
    .tag_match1(tag_match1), .tag_match2(tag_match2),
    .hit1(hit1), .hit2(hit2), .load_way1(load_way1), .load_way2(load_way2),
    .data_sel(data_sel), .pmem_addr_sel(pmem_addr_sel), .victim_way(victim_way),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Output vector: {mem_resp,hit1,hit2,load1,load2,data_sel,addr_sel,pmem_read,pmem_write}
  task automatic cyc_check(input string tag, input logic [8:0] exp, input logic [8:0] mask);
    logic [8:0] obs;
    logic l1, l2;
    #2;
    obs = {mem_resp, hit1, hit2, load_way1, load_way2, data_sel,
           pmem_addr_sel, pmem_read, pmem_write};
    vectors++;
    assert ((obs & mask) === (exp & mask)) else begin
      miscompares++;
      $error("FAIL %s: observed %b required %b (mask %b)", tag, obs, exp, mask);
    end
    l1 = load_way1;
    l2 = load_way2;
    @(posedge clk);
    if (l1) dp_tag[0][w_set] = w_tag;
    if (l2) dp_tag[1][w_set] = w_tag;
    #1;
  endtask

  function automatic logic [1:0] exp_hits();
    logic h1, h2;
    h1 = mval[0][w_set] && (mtag[0][w_set] == w_tag);
    h2 = mval[1][w_set] && (mtag[1][w_set] == w_tag) && !h1;
    return {h1, h2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSETS; i++) begin
      mval[0][i] = 0; mval[1][i] = 0;
      mdir[0][i] = 0; mdir[1][i] = 0;
      mlru[i] = 0;
    end
  endtask

  task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input int unsigned wbl, input int unsigned all);
    logic [1:0] h;
    logic [2:0] s;
    logic [23:0] t;
    bit v, last;
    mem_read = rd; mem_write = wr; mem_address = addr;
    s = addr[7:5]; t = addr[31:8];
    h = exp_hits();
    cyc_check("idle", {1'b0, h, 6'b0}, 9'b111110011);
    for (int pass = 0; pass < 2; pass++) begin
      h = exp_hits();
      if (h != 2'b00) begin
        cyc_check("cmp_hit", {1'b1, h, wr & h[1], wr & h[0], 4'b0000},
                  wr ? 9'b111111011 : 9'b111110011);
        mlru[s] = h[1];
        if (wr) mdir[h[1] ? 0 : 1][s] = 1;
        mem_read = 0; mem_write = 0;
        return;
      end
      v = mlru[s];
      chk1("cmp_victim", victim_way, v);
      cyc_check("cmp_miss", {1'b0, h, 6'b0}, 9'b111110011);
      if (mval[v][s] && mdir[v][s]) begin
        for (int unsigned i = 1; i <= wbl; i++) begin
          pmem_resp = (i == wbl);
          chk1("wb_victim", victim_way, v);
          cyc_check("wb", {1'b0, h, 6'b000101}, 9'b111110111);
          pmem_resp = 0;
        end
        mdir[v][s] = 0;
      end
      for (int unsigned i = 1; i <= all; i++) begin
        last = (i == all);
        pmem_resp = last;
        chk1("alloc_victim", victim_way, v);
        cyc_check("alloc", {1'b0, h, last && !v, last && v, last, 3'b010},
                  last ? 9'b111111111 : 9'b111110111);
        pmem_resp = 0;
      end
      mval[v][s] = 1; mdir[v][s] = 0; mtag[v][s] = t;
    end
    // The model always predicts a hit after the fill, so this is not reached.
    mem_read = 0; mem_write = 0;
  endtask

  task automatic run_cancel(input logic [31:0] addr);
    logic [1:0] h;
    mem_read = 1; mem_write = 0; mem_address = addr;
    h = exp_hits();
    cyc_check("cancel_idle", {1'b0, h, 6'b0}, 9'b111110011);
    mem_read = 0;
    cyc_check("cancel_cmp", {1'b0, h, 6'b0}, 9'b111110011);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned k;
    rst = 1; mem_read = 0; mem_write = 0; pmem_resp = 0;
    mem_address = 32'h0000_0040;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < NSETS; i++) begin
        dp_tag[w][i] = 24'($urandom_range(0, 3));
        mtag[w][i]   = dp_tag[w][i];
      end
    model_reset();
    @(posedge clk); #1;
    chk1("rst_victim", victim_way, 1'b0);
    cyc_check("rst_outputs", 9'b0, 9'b111111111);
    rst = 0;

    // Cold miss to set 0, then the set-2 sequence.
    run_req(1, 0, 32'h0000_0000, 1, 2);
    run_req(1, 0, 32'h0000_0040, 1, 4);
    chk1("lru2_after_fill", victim_way, 1'b1);
    run_req(1, 0, 32'h0000_0040, 1, 1);
    run_req(0, 1, 32'h0000_0040, 1, 1);
    run_req(1, 0, 32'h0000_0140, 1, 3);
    chk1("lru2_after_way2", victim_way, 1'b0);
    run_req(1, 0, 32'h0000_0240, 3, 2);
    chk1("lru2_after_evict", victim_way, 1'b1);

    // Priority: both ways valid with identical tags in set 3.
    run_req(1, 0, 32'h0000_0060, 1, 1);
    run_req(1, 0, 32'h0000_0160, 1, 1);
    dp_tag[1][3] = mtag[0][3];
    mtag[1][3]   = mtag[0][3];
    run_req(1, 0, 32'h0000_0060, 1, 1);
    chk1("prio_lru", victim_way, 1'b1);

    // Request withdrawn before compare.
    run_cancel(32'h0000_0080);

    // Abort: two dirty ways in set 5, dirty miss, reset during writeback.
    run_req(0, 1, 32'h0000_00A0, 1, 1);
    run_req(0, 1, 32'h0000_01A0, 1, 1);
    mem_read = 1; mem_address = 32'h0000_02A0;
    cyc_check("abort_idle", {1'b0, exp_hits(), 6'b0}, 9'b111110011);
    cyc_check("abort_cmp", {1'b0, exp_hits(), 6'b0}, 9'b111110011);
    cyc_check("abort_wb1", {1'b0, exp_hits(), 6'b000101}, 9'b111110111);
    #2;
    chk1("abort_pw_before", pmem_write, 1'b1);
    #1 rst = 1;
    #1;
    chk1("abort_pw_drop", pmem_write, 1'b0);
    chk1("abort_pr_drop", pmem_read, 1'b0);
    chk1("abort_resp", mem_resp, 1'b0);
    mem_read = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    run_req(1, 0, 32'h0000_00A0, 1, 2);
    run_req(0, 1, 32'h0000_01A0, 2, 1);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      a = {22'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7)), 5'($urandom)};
      a[31:8] = 24'($urandom_range(0, 3));
      k = $urandom_range(0, 9);
      if (k == 0) run_cancel(a);
      else begin
        k = $urandom_range(0, 2);
        run_req(k != 1, k != 0, a, $urandom_range(1, 4), $urandom_range(1, 4));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
